digit_frame_display: RTL and testbench

DIGIT_FRAME_DISPLAY -- requirements
Module: digit_frame_display

---
 rtl/display_pkg.sv | 21 ++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/digit_frame_display.sv | 139 +++++++++++++
 tb/tb_digit_frame_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit seven-segment frame display.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes go blank.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_frame_display.sv
// Receives 4-digit BCD frames into a shadow buffer, commits them atomically to
// the display registers, and multiplexes the digits onto a common-anode display.
module digit_frame_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int LZB      = 0,
  parameter int DP_POS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  input  logic       dv,
  input  logic       sof,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int PW = $clog2(SCAN_DIV);

  // Receiver state: digits 0..2 wait in the shadow; digit 3 goes straight to display
  logic [3:0] shadow_reg  [0:NUM_DIGITS-2];
  logic [3:0] shadow_next [0:NUM_DIGITS-2];
  logic [1:0] idx_reg;
  logic       active_reg;
  logic [NUM_DIGITS-1:0][3:0] disp_reg;
  logic       done_reg;
  logic       err_reg;

  // Scanner state
  logic [PW-1:0] presc_reg;
  logic [1:0]    scan_reg;

  // Output registers
  logic [3:0] an_reg;
  logic [6:0] seg_reg;
  logic       dp_reg;

  logic wr_sof, wr_cont, commit, orphan;

  assign wr_sof  = dv && sof;
  assign wr_cont = dv && !sof && active_reg && (idx_reg != 2'd3);
  assign commit  = dv && !sof && active_reg && (idx_reg == 2'd3);
  assign orphan  = dv && !sof && !active_reg;

  // Each shadow slot captures d when it is the current write target
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_shadow
      if (gi == 0) begin : g_first
        assign shadow_next[gi] = (wr_sof || (wr_cont && idx_reg == 2'd0)) ? d : shadow_reg[gi];
      end else begin : g_rest
        assign shadow_next[gi] = (wr_cont && idx_reg == 2'(gi)) ? d : shadow_reg[gi];
      end
    end
  endgenerate

  // Frame receiver: sof restarts, continuation digits fill in order, digit 3 commits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS - 1; k++) shadow_reg[k] <= 4'd0;
      idx_reg    <= 2'd0;
      active_reg <= 1'b0;
      disp_reg   <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      shadow_reg <= shadow_next;
      done_reg   <= commit;
      err_reg    <= orphan;
      if (wr_sof) begin
        idx_reg    <= 2'd1;
        active_reg <= 1'b1;
      end else if (wr_cont) begin
        idx_reg <= idx_reg + 2'd1;
      end else if (commit) begin
        disp_reg   <= {d, shadow_reg[2], shadow_reg[1], shadow_reg[0]};
        idx_reg    <= 2'd0;
        active_reg <= 1'b0;
      end
    end
  end

  // Prescaler and digit scan index, independent of the receive path
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
      scan_reg  <= 2'd0;
    end else if (presc_reg == PW'(SCAN_DIV - 1)) begin
      presc_reg <= '0;
      scan_reg  <= scan_reg + 2'd1;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Per-digit decode and leading-zero blanking chain from the top digit down
  logic [NUM_DIGITS-1:0][6:0] dec_seg;
  logic [NUM_DIGITS-1:0]      blank;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_to_seg u_dec (
        .bcd (disp_reg[gi]),
        .seg (dec_seg[gi])
      );
      if (gi == 0) begin : g_b0
        assign blank[gi] = 1'b0;
      end else if (gi == NUM_DIGITS - 1) begin : g_btop
        assign blank[gi] = (LZB != 0) && (disp_reg[gi] == 4'd0);
      end else begin : g_bmid
        assign blank[gi] = (LZB != 0) && (disp_reg[gi] == 4'd0) && blank[gi+1];
      end
    end
  endgenerate

  // Registered anode/segment/dp drive for the digit currently being scanned
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= 4'b1110;
      seg_reg <= SEG_0;
      dp_reg  <= (DP_POS == 0) ? 1'b0 : 1'b1;
    end else begin
      an_reg  <= ~(4'd1 << scan_reg);
      seg_reg <= blank[scan_reg] ? SEG_BLANK : dec_seg[scan_reg];
      dp_reg  <= !((scan_reg == 2'(DP_POS)) && !blank[scan_reg]);
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = done_reg;
  assign frame_err  = err_reg;

endmodule

// File: tb/tb_digit_frame_display.sv
// Directed bench: three DUTs (LZB=0/DP_POS=2, LZB=1/DP_POS=2, LZB=0/DP_POS=0)
// share stimulus; frame vectors come from a table, reset/scan timing by hand.
module tb_digit_frame_display;

  logic clk = 1'b0;
  logic rst, dv, sof;
  logic [3:0] d;

  logic [3:0] an0, an1, an2;
  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic       done0, done1, done2;
  logic       err0, err1, err2;

  digit_frame_display #(.SCAN_DIV(4), .LZB(0), .DP_POS(2)) dut0 (
    .clk(clk), .rst(rst), .d(d), .dv(dv), .sof(sof),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(done0), .frame_err(err0));

  digit_frame_display #(.SCAN_DIV(4), .LZB(1), .DP_POS(2)) dut1 (
    .clk(clk), .rst(rst), .d(d), .dv(dv), .sof(sof),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(done1), .frame_err(err1));

  digit_frame_display #(.SCAN_DIV(4), .LZB(0), .DP_POS(0)) dut2 (
    .clk(clk), .rst(rst), .d(d), .dv(dv), .sof(sof),
    .an(an2), .seg(seg2), .dp(dp2), .frame_done(done2), .frame_err(err2));

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Running pulse totals, sampled away from the active edge
  int done_tot0 = 0, err_tot0 = 0, done_tot1 = 0, err_tot1 = 0;
  always @(negedge clk) begin
    if (done0) done_tot0++;
    if (err0)  err_tot0++;
    if (done1) done_tot1++;
    if (err1)  err_tot1++;
  end

  typedef struct {
    int              n;
    logic [5:0][3:0] d;
    logic [5:0]      dv;
    logic [5:0]      sof;
    logic [5:0]      rs;
    logic [3:0][6:0] s0;
    logic [3:0][6:0] s1;
    logic [3:0]      p0;
    logic [3:0]      p1;
    int              nd;
    int              ne;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [23:0] dd, input logic [5:0] ddv,
                     input logic [5:0] ssof, input logic [5:0] rrs,
                     input logic [27:0] ss0, input logic [27:0] ss1,
                     input logic [3:0] pp0, input logic [3:0] pp1,
                     input int nd, input int ne);
    vec_t v;
    v.n = n; v.d = dd; v.dv = ddv; v.sof = ssof; v.rs = rrs;
    v.s0 = ss0; v.s1 = ss1; v.p0 = pp0; v.p1 = pp1; v.nd = nd; v.ne = ne;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (an0 === want && an1 === want) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic apply(input int k);
    vec_t v;
    int   d0, e0, d1, e1;
    bit   ok;
    logic [3:0] want;
    v  = vecs[k];
    d0 = done_tot0; e0 = err_tot0; d1 = done_tot1; e1 = err_tot1;
    for (int i = 0; i < v.n; i++) begin
      rst = v.rs[i]; dv = v.dv[i]; sof = v.sof[i]; d = v.d[i];
      step();
      if (i == v.n - 1 && v.nd > 0) begin
        check($sformatf("v%0d done timing lzb0", k), {31'd0, done0}, 32'd1);
        check($sformatf("v%0d done timing lzb1", k), {31'd0, done1}, 32'd1);
      end
    end
    rst = 1'b0; dv = 1'b0; sof = 1'b0; d = 4'd0;
    repeat (3) step();
    check($sformatf("v%0d done count lzb0", k), done_tot0 - d0, v.nd);
    check($sformatf("v%0d err count lzb0", k),  err_tot0 - e0,  v.ne);
    check($sformatf("v%0d done count lzb1", k), done_tot1 - d1, v.nd);
    check($sformatf("v%0d err count lzb1", k),  err_tot1 - e1,  v.ne);
    for (int s = 0; s < 4; s++) begin
      want = ~(4'd1 << s);
      wait_an(want, ok);
      check($sformatf("v%0d slot%0d reached", k, s), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d slot%0d seg lzb0", k, s), {25'd0, seg0}, {25'd0, v.s0[s]});
      check($sformatf("v%0d slot%0d seg lzb1", k, s), {25'd0, seg1}, {25'd0, v.s1[s]});
      check($sformatf("v%0d slot%0d dp lzb0", k, s),  {31'd0, dp0},  {31'd0, v.p0[s]});
      check($sformatf("v%0d slot%0d dp lzb1", k, s),  {31'd0, dp1},  {31'd0, v.p1[s]});
    end
    $display("vec %0d: %0d steps applied, checks so far %0d, miscompares %0d",
             k, v.n, vec_cnt, miss_cnt);
  endtask

  logic [3:0] exp_seq [4];
  logic [3:0] prev_an;
  int         t_last, nchg;

  initial begin
    exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1011;
    exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1110;

    //  n  digits      dv         sof        rst        seg lzb0 {s3,s2,s1,s0}        seg lzb1                      dp0      dp1     done err
    add(4, 24'h001234, 6'b001111, 6'b000001, 6'b000000, {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}, 4'b1011, 4'b1011, 1, 0);
    add(6, 24'h078965, 6'b111111, 6'b000101, 6'b000000, {7'h40,7'h78,7'h00,7'h10}, {7'h7F,7'h78,7'h00,7'h10}, 4'b1011, 4'b1011, 1, 0);
    add(1, 24'h000007, 6'b000001, 6'b000000, 6'b000000, {7'h40,7'h78,7'h00,7'h10}, {7'h7F,7'h78,7'h00,7'h10}, 4'b1011, 4'b1011, 0, 1);
    add(4, 24'h000005, 6'b001111, 6'b000001, 6'b000000, {7'h40,7'h40,7'h40,7'h12}, {7'h7F,7'h7F,7'h7F,7'h12}, 4'b1011, 4'b1111, 1, 0);
    add(4, 24'h000000, 6'b001111, 6'b000001, 6'b000000, {7'h40,7'h40,7'h40,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'b1011, 4'b1111, 1, 0);
    add(4, 24'h0080FA, 6'b001111, 6'b000001, 6'b000000, {7'h00,7'h40,7'h7F,7'h7F}, {7'h00,7'h40,7'h7F,7'h7F}, 4'b1011, 4'b1011, 1, 0);
    add(2, 24'h000023, 6'b000010, 6'b000001, 6'b000000, {7'h00,7'h40,7'h7F,7'h7F}, {7'h00,7'h40,7'h7F,7'h7F}, 4'b1011, 4'b1011, 0, 1);
    add(4, 24'h000103, 6'b001111, 6'b000001, 6'b000000, {7'h40,7'h79,7'h40,7'h30}, {7'h7F,7'h79,7'h40,7'h30}, 4'b1011, 4'b1011, 1, 0);
    add(5, 24'h043021, 6'b011011, 6'b000001, 6'b000100, {7'h40,7'h40,7'h40,7'h40}, {7'h7F,7'h7F,7'h7F,7'h40}, 4'b1011, 4'b1111, 0, 2);

    // Reset state of all outputs
    rst = 1'b1; dv = 1'b1; sof = 1'b1; d = 4'd8;
    repeat (3) step();
    check("reset an",         {28'd0, an0},   32'hE);
    check("reset seg",        {25'd0, seg0},  32'h40);
    check("reset dp dp2",     {31'd0, dp0},   32'd1);
    check("reset dp dp0",     {31'd0, dp2},   32'd0);
    check("reset frame_done", {31'd0, done0}, 32'd0);
    check("reset frame_err",  {31'd0, err0},  32'd0);
    check("reset seg lzb1",   {25'd0, seg1},  32'h40);
    $display("reset: an=%b seg=%h dp=%b", an0, seg0, dp0);

    // Scan sequence and slot period after reset release
    dv = 1'b0; sof = 1'b0; d = 4'd0; rst = 1'b0;
    prev_an = an0; t_last = 0; nchg = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (an0 !== prev_an) begin
        if (nchg > 0) check("scan period", c - t_last, 32'd4);
        check("scan order", {28'd0, an0}, {28'd0, exp_seq[nchg]});
        check("scan seg zero", {25'd0, seg0}, 32'h40);
        check("scan dp", {31'd0, dp0}, (an0 == 4'b1011) ? 32'd0 : 32'd1);
        $display("scan: cycle %0d an=%b seg=%h dp=%b", c, an0, seg0, dp0);
        t_last  = c;
        prev_an = an0;
        nchg++;
        if (nchg == 4) break;
      end
    end
    check("scan slots seen", nchg, 32'd4);

    for (int k = 0; k < vecs.size(); k++) apply(k);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
